// File: rtl/seg7_scan_decoder.sv
// Multiplexed seven-segment bus readback: debounces {dig_sel,seg} and decodes glyphs to BCD.
// Optional SEG7_ALT_GLYPH_EN also accepts the tail-less 6/9 and the F-segment 7.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done
);

  localparam int PW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 1);

  logic [PW-1:0]         pair;
  logic [PW-1:0]         samp;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] captured;
  logic [NUM_DIGITS-1:0] cap_next;
  logic                  changed;
  logic                  one_hot;
  logic                  hit;
  logic                  legal;
  logic [3:0]            val;

  assign pair    = {dig_sel, seg};
  assign changed = (pair != samp);
  assign one_hot = (dig_sel != '0) &&
                   ((dig_sel & (dig_sel - 1'b1)) == '0);
  // cnt reaches STABLE_CYCLES-1 on the edge before the final hold edge
  assign hit      = !changed && one_hot && (cnt == CNT_HIT);
  assign cap_next = captured | dig_sel;

  always_comb begin
    legal = 1'b1;
    val   = 4'd0;
    case (seg)
      7'h7E: val = 4'd0;
      7'h30: val = 4'd1;
      7'h6D: val = 4'd2;
      7'h79: val = 4'd3;
      7'h33: val = 4'd4;
      7'h5B: val = 4'd5;
      7'h5F: val = 4'd6;
      7'h70: val = 4'd7;
      7'h7F: val = 4'd8;
      7'h7B: val = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
      7'h1F: val = 4'd6;
      7'h72: val = 4'd7;
      7'h73: val = 4'd9;
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp        <= '0;
      cnt         <= '0;
      captured    <= '0;
      bcd         <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      frame_done  <= 1'b0;
    end else begin
      samp       <= pair;
      frame_done <= 1'b0;
      if (changed || !one_hot)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (hit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_sel[i]) begin
            if (legal)
              bcd[4*i +: 4] <= val;
            digit_valid[i] <= legal;
            digit_err[i]   <= !legal;
          end
        end
        if (&cap_next) begin
          frame_done <= 1'b1;
          captured   <= '0;
        end else begin
          captured <= cap_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: run-length reference model, queued expectations.
// Honours SEG7_ALT_GLYPH_EN in the reference glyph table.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam int S = 4;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] bcd;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        frame_done;

  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
    .bcd(bcd), .digit_valid(digit_valid),
    .digit_err(digit_err), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  exp_t q[$];

  logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] alt_seg [3] = '{7'h1F, 7'h72, 7'h73};
  logic [3:0] alt_val [3] = '{4'd6, 4'd7, 4'd9};

  // reference state
  logic [3:0]  m_val [4];
  logic [3:0]  m_valid, m_err, m_cap;
  logic [10:0] m_prev;
  int          m_run;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit lookup(input logic [6:0] s, output logic [3:0] v);
    v = 4'd0;
    for (int k = 0; k < 10; k++)
      if (glyph[k] == s) begin v = 4'(k); return 1'b1; end
`ifdef SEG7_ALT_GLYPH_EN
    for (int k = 0; k < 3; k++)
      if (alt_seg[k] == s) begin v = alt_val[k]; return 1'b1; end
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = 4'd0;
    m_valid = '0; m_err = '0; m_cap = '0;
    m_prev = '0; m_run = 0;
  endtask

  // one clock edge of the reference: a pair captures on its (S+1)-th
  // consecutive sample, exactly once per hold
  function automatic exp_t model_edge(input logic [3:0] d, input logic [6:0] s);
    exp_t e;
    logic [3:0] v;
    bit ok;
    int cnt1;
    if ({d, s} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {d, s};
    e.fd = 1'b0;
    cnt1 = $countones(d);
    if (cnt1 == 1 && m_run == S + 1) begin
      ok = lookup(s, v);
      for (int i = 0; i < 4; i++) begin
        if (d[i]) begin
          if (ok) m_val[i] = v;
          m_valid[i] = ok;
          m_err[i]   = !ok;
        end
      end
      m_cap = m_cap | d;
      if (m_cap == 4'hF) begin
        e.fd  = 1'b1;
        m_cap = '0;
      end
    end
    e.bcd   = {m_val[3], m_val[2], m_val[1], m_val[0]};
    e.valid = m_valid;
    e.err   = m_err;
    return e;
  endfunction

  task automatic step(input logic [3:0] d, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      dig_sel = d;
      seg     = s;
      q.push_back(model_edge(d, s));
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("bcd", 32'(bcd), 32'(e.bcd));
      check("digit_valid", 32'(digit_valid), 32'(e.valid));
      check("digit_err", 32'(digit_err), 32'(e.err));
      check("frame_done", 32'(frame_done), 32'(e.fd));
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_bcd"}, 32'(bcd), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_err"}, 32'(digit_err), 32'h0);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    logic [3:0] d;
    logic [6:0] s;
    int r;
    rst = 1'b1;
    seg = '0;
    dig_sel = '0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // single capture, then reset in the middle of a fresh hold
    step(4'b0001, 7'h7E, 6);
    step(4'b0010, 7'h30, 3);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b0001, 7'h7E, 6);

    // full scan -> 5432 and one frame_done pulse
    step(4'b0001, 7'h6D, 6);
    step(4'b0010, 7'h79, 6);
    step(4'b0100, 7'h33, 6);
    step(4'b1000, 7'h5B, 6);

    // glitch then settle on 1
    step(4'b0010, 7'h7B, 2);
    step(4'b0010, 7'h30, 6);

    // alternate 6 glyph
    step(4'b0100, 7'h1F, 6);

    // multi-hot select never captures
    step(4'b0011, 7'h7F, 10);
    step(4'b0000, 7'h7F, 5);

    // randomized holds
    for (int h = 0; h < 200; h++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 70) s = glyph[$urandom_range(0, 9)];
      else if (r < 85) s = alt_seg[$urandom_range(0, 2)];
      else s = 7'($urandom);
      step(d, s, int'($urandom_range(1, 7)));
    end

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
